// File: rtl/shift_sequencer.sv
// shift_sequencer: sequential shifter, one bit per clock (SLL / SRL / SRA / pass-through).
// Latency: shamt+1 cycles from start to done (1 for shamt=0 or op=11); throughput shamt+2.
// Backpressure: start is taken only while ready=1; otherwise it is dropped, so the requester re-issues.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   start, op, shamt,    request; op 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   operand
//   flush                aborts an in-flight shift (SHIFT state only)
//   ready, busy, done    status: IDLE / SHIFT / one-cycle completion pulse
//   result               last completed result, held until the next completion
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   operand,
  input  logic               flush,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  // Counter is one bit wider than the amount; the amount is zero-extended into it.
  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   result_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;

  // One-bit step of the working register for the latched shift type.
  always_comb begin
    work_d = work_q;
    case (op_q)
      2'b00:   work_d = {work_q[WIDTH-2:0], 1'b0};
      2'b01:   work_d = {1'b0, work_q[WIDTH-1:1]};
      2'b10:   work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: work_d = work_q;
    endcase
    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            work_q  <= operand;
            op_q    <= op;
            cnt_q   <= {1'b0, shamt};
            ready_q <= 1'b0;
            if ((shamt == '0) || (op == 2'b11)) begin
              // Nothing to shift: publish the operand directly.
              state_q  <= S_DONE;
              result_q <= operand;
              done_q   <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (flush) begin
            // Abort wins over completion; result keeps the previous value.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            if (cnt_q == CNT_W'(1)) begin
              // Last bit shifted this edge: publish the post-shift value.
              state_q  <= S_DONE;
              result_q <= work_d;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: randomized and directed requests, scoreboard of expected
// results/latencies computed with plain shift operators, monitor compares on every done.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] operand;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .operand (operand),
    .flush   (flush),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          nbusy;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole shift at once, straight from the operation's definition.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input int s, input logic [31:0] v);
    logic signed [31:0] sv;
    sv = v;
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return sv >>> s;
      default: return v;
    endcase
  endfunction

  // Monitor: status exclusivity, result hold, and scoreboard pop on done.
  logic [31:0] held = '0;
  int          busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held     = '0;
      busy_cnt = 0;
    end else begin
      chk("status_onehot", $countones({ready, busy, done}), 1);
      if (ready) busy_cnt = 0;
      if (busy)  busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with result %h, required no done (cycle %0d)", result, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, e.nbusy);
          held = e.res;
        end
        busy_cnt = 0;
      end else begin
        chk("result_held", result, held);
      end
    end
  end

  // Issue one request at the first ready cycle; optionally spray ignored starts
  // while not ready, and/or raise flush at loop index flush_at.
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] v,
                       input int junk, input int flush_at);
    int   t;
    int   eff;
    exp_t e;
    t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", t);
      return;
    end
    eff     = (o == 2'b11) ? 0 : int'(s);
    start   = 1'b1;
    op      = o;
    shamt   = s;
    operand = v;
    e.res   = ref_shift(o, int'(s), v);
    e.cyc   = cyc + 1 + eff;
    e.nbusy = eff;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!ready && t < 100) begin
      logic pop_it;
      pop_it = 1'b0;
      if (t == flush_at) begin
        flush  = 1'b1;
        pop_it = busy;
      end
      if (junk != 0) begin
        start   = 1'b1;
        op      = 2'($urandom_range(0, 3));
        shamt   = 5'($urandom_range(0, 31));
        operand = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (pop_it) void'(exp_q.pop_back());
      t++;
    end
  endtask

  initial begin
    int t;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    shamt   = '0;
    operand = '0;
    flush   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(2'b00, 5'd31, 32'h0000_0001, 0, -1);
    issue(2'b10, 5'd4,  32'h8000_00F0, 0, -1);
    issue(2'b01, 5'd4,  32'h8000_00F0, 0, -1);
    issue(2'b00, 5'd0,  32'hDEAD_BEEF, 0, -1);
    issue(2'b11, 5'd7,  32'h1234_5678, 0, -1);
    issue(2'b10, 5'd31, 32'h8000_0000, 0, -1);
    issue(2'b00, 5'd10, 32'h0000_00A5, 0, 2);
    issue(2'b01, 5'd3,  32'hF000_000F, 0, -1);
    issue(2'b01, 5'd6,  32'hCAFE_F00D, 1, -1);
    issue(2'b10, 5'd0,  32'h8765_4321, 0, 0);
    issue(2'b00, 5'd1,  32'h4000_0001, 0, 1);

    // Reset in the middle of a long shift
    while (!ready) @(negedge clk);
    start   = 1'b1;
    op      = 2'b00;
    shamt   = 5'd20;
    operand = 32'h0000_0F0F;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", ready, 1);
    chk("midreset_result", result, 0);
    chk("midreset_done", done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [1:0] o;
      logic [4:0] s;
      int         fa;
      o  = 2'($urandom_range(0, 3));
      s  = 5'($urandom_range(0, 31));
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) % (int'(s) + 1) : -1;
      issue(o, s, $urandom, int'($urandom_range(0, 1)), fa);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding requests, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
